// File: rtl/point_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : point_scheduler
//  Description : Round-robin arbiter plus slot timer that time-multiplexes one
//                LED-cube point display between NUM_SRC animated-point sources.
//                Each slot latches one requester's (x,y,z,colour) and holds it
//                on the display for SLOT_CYCLES clocks.
//  Revision    : 1.0  initial release
// ============================================================================
module point_scheduler #(
  parameter int NUM_SRC     = 4,
  parameter int SLOT_CYCLES = 50000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pause,
  input  logic [NUM_SRC-1:0]           req,
  input  logic [3*NUM_SRC-1:0]         src_x,
  input  logic [3*NUM_SRC-1:0]         src_y,
  input  logic [3*NUM_SRC-1:0]         src_z,
  input  logic [3*NUM_SRC-1:0]         src_c,
  output logic [NUM_SRC-1:0]           grant,
  output logic [$clog2(NUM_SRC)-1:0]   cur_src,
  output logic                         disp_en,
  output logic [2:0]                   disp_x,
  output logic [2:0]                   disp_y,
  output logic [2:0]                   disp_z,
  output logic [2:0]                   disp_c,
  output logic                         slot_done
);

  localparam int SW = $clog2(NUM_SRC);
  localparam int CW = $clog2(SLOT_CYCLES);

  localparam logic [CW-1:0]      c_cnt_last  = CW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0]      c_last_init = SW'(NUM_SRC - 1);
  localparam logic [SW:0]        c_num_src   = (SW+1)'(NUM_SRC);
  localparam logic [NUM_SRC-1:0] c_one       = NUM_SRC'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        last_q, last_d;
  logic [SW-1:0]        cur_src_q, cur_src_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic                 disp_en_q, disp_en_d;
  logic [2:0]           disp_x_q, disp_x_d;
  logic [2:0]           disp_y_q, disp_y_d;
  logic [2:0]           disp_z_q, disp_z_d;
  logic [2:0]           disp_c_q, disp_c_d;
  logic                 slot_done_q, slot_done_d;

  logic [2:0]           w_pt_x [NUM_SRC];
  logic [2:0]           w_pt_y [NUM_SRC];
  logic [2:0]           w_pt_z [NUM_SRC];
  logic [2:0]           w_pt_c [NUM_SRC];
  logic [SW:0]          w_sum;
  logic [SW-1:0]        w_win_idx;
  logic                 w_win_found;
  logic                 w_cur_req;

  // Split the packed source buses into per-source 3-bit fields.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign w_pt_x[i] = src_x[3*i +: 3];
    assign w_pt_y[i] = src_y[3*i +: 3];
    assign w_pt_z[i] = src_z[3*i +: 3];
    assign w_pt_c[i] = src_c[3*i +: 3];
  end

  assign w_cur_req = req[cur_src_q];

  // Circular search for the first requester after the previous winner.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_sum       = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      w_sum = {1'b0, last_q} + (SW+1)'(k);
      if (w_sum >= c_num_src) begin
        w_sum = w_sum - c_num_src;
      end
      if (!w_win_found && req[w_sum[SW-1:0]]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_sum[SW-1:0];
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/ARB/SHOW controller.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    cur_src_d   = cur_src_q;
    grant_d     = '0;
    slot_done_d = 1'b0;
    disp_en_d   = disp_en_q;
    disp_x_d    = disp_x_q;
    disp_y_d    = disp_y_q;
    disp_z_d    = disp_z_q;
    disp_c_d    = disp_c_q;

    case (state_q)
      ST_IDLE: begin
        disp_en_d = 1'b0;
        if (|req) begin
          state_d = ST_ARB;
        end
      end

      ST_ARB: begin
        if (!w_win_found) begin
          // Nobody left to show: blank the display.
          disp_en_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          disp_x_d  = w_pt_x[w_win_idx];
          disp_y_d  = w_pt_y[w_win_idx];
          disp_z_d  = w_pt_z[w_win_idx];
          disp_c_d  = w_pt_c[w_win_idx];
          cur_src_d = w_win_idx;
          last_d    = w_win_idx;
          grant_d   = c_one << w_win_idx;
          disp_en_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_SHOW;
        end
      end

      ST_SHOW: begin
        disp_en_d = 1'b1;
        if (!w_cur_req) begin
          // Displayed source withdrew: end the slot early, pause notwithstanding.
          slot_done_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_ARB;
        end else if (!pause) begin
          if (cnt_q == c_cnt_last) begin
            slot_done_d = 1'b1;
            cnt_d       = '0;
            state_d     = ST_ARB;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= c_last_init;
      cur_src_q   <= '0;
      grant_q     <= '0;
      disp_en_q   <= 1'b0;
      disp_x_q    <= 3'd0;
      disp_y_q    <= 3'd0;
      disp_z_q    <= 3'd0;
      disp_c_q    <= 3'd0;
      slot_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      cur_src_q   <= cur_src_d;
      grant_q     <= grant_d;
      disp_en_q   <= disp_en_d;
      disp_x_q    <= disp_x_d;
      disp_y_q    <= disp_y_d;
      disp_z_q    <= disp_z_d;
      disp_c_q    <= disp_c_d;
      slot_done_q <= slot_done_d;
    end
  end

  assign grant     = grant_q;
  assign cur_src   = cur_src_q;
  assign disp_en   = disp_en_q;
  assign disp_x    = disp_x_q;
  assign disp_y    = disp_y_q;
  assign disp_z    = disp_z_q;
  assign disp_c    = disp_c_q;
  assign slot_done = slot_done_q;

endmodule
`default_nettype wire
